// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment pattern constants and hex decoder
// Patterns are active-high, ordered {g,f,e,d,c,b,a} with segment a in bit 0.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] seg7_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = SEG_A;
            4'hB:    pat = SEG_B;
            4'hC:    pat = SEG_C;
            4'hD:    pat = SEG_D;
            4'hE:    pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/multi_digit_tube_scanner_if.sv
// rtl/multi_digit_tube_scanner_if.sv - command and display bus of the tube scanner
// master: drives i_inc/i_dec/i_clr pulses, observes display and value.
// slave:  the scanner; consumes commands, drives o_digitalTube/o_sel/o_value/o_wrap.
interface multi_digit_tube_scanner_if #(
    parameter int N_DIGITS = 4
);
    logic                    i_inc;
    logic                    i_dec;
    logic                    i_clr;
    logic [6:0]              o_digitalTube;
    logic [N_DIGITS-1:0]     o_sel;
    logic [4*N_DIGITS-1:0]   o_value;
    logic                    o_wrap;

    modport master (
        output i_inc, i_dec, i_clr,
        input  o_digitalTube, o_sel, o_value, o_wrap
    );

    modport slave (
        input  i_inc, i_dec, i_clr,
        output o_digitalTube, o_sel, o_value, o_wrap
    );
endinterface

// File: rtl/multi_digit_tube_scanner_scan_timer.sv
// rtl/multi_digit_tube_scanner_scan_timer.sv - refresh prescaler and round-robin digit index
// i_clk, i_rst : clock, synchronous active-high reset
// index        : digit currently being scanned (0..N_DIGITS-1)
// advance      : high on the last prescaler cycle of a slot; index moves on that edge
module seg7_scan_timer #(
    parameter int SCAN_DIV = 100000,
    parameter int N_DIGITS = 4,
    parameter int IDX_W    = $clog2(N_DIGITS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [IDX_W-1:0] index,
    output logic             advance
);
    localparam int               PRE_W    = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [PRE_W-1:0] prescale;

    assign advance = (prescale == PRE_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prescale <= '0;
            index    <= '0;
        end else if (advance) begin
            prescale <= '0;
            index    <= (index == IDX_LAST) ? '0 : index + 1'b1;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

endmodule

// File: rtl/multi_digit_tube_scanner.sv
// rtl/multi_digit_tube_scanner.sv - N-digit up/down counter on a multiplexed 7-segment display
// i_clk, i_rst : clock, synchronous active-high reset
// bus (slave)  : i_inc/i_dec/i_clr one-cycle command pulses (clear wins, inc+dec cancel);
//                o_value packed digits (digit k at [4k+3:4k]), o_wrap one-cycle wrap pulse,
//                o_sel one-hot digit select, o_digitalTube {g..a} segments.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 always shown).
module multi_digit_tube_scanner #(
    parameter int N_DIGITS       = 4,
    parameter int RADIX          = 10,
    parameter int SCAN_DIV       = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    multi_digit_tube_scanner_if.slave bus
);
    import seg7_pkg::*;

    localparam int                  IDX_W     = $clog2(N_DIGITS);
    localparam logic [3:0]          DIGIT_MAX = 4'(RADIX - 1);
    localparam logic [6:0]          SEG_POL   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] SEL_POL   = SEL_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

    if (!(RADIX == 10 || RADIX == 16)) begin : g_bad_radix
        $error("multi_digit_tube_scanner: RADIX must be 10 or 16");
    end
    if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_digits
        $error("multi_digit_tube_scanner: N_DIGITS must be 2..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("multi_digit_tube_scanner: SCAN_DIV must be >= 2");
    end

    logic [4*N_DIGITS-1:0] value_q;
    logic [4*N_DIGITS-1:0] next_value;
    logic                  wrap_q;
    logic                  next_wrap;
    logic                  carry;

    logic [3:0]            digits [N_DIGITS];
    logic [IDX_W-1:0]      scan_index;
    logic                  scan_advance;
    logic [N_DIGITS-1:0]   lead_blank;
    logic [3:0]            cur_digit;
    logic [6:0]            cur_pattern;
    logic [N_DIGITS-1:0]   cur_sel;

    seg7_scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .N_DIGITS (N_DIGITS),
        .IDX_W    (IDX_W)
    ) u_scan_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .index   (scan_index),
        .advance (scan_advance)
    );

    // Ripple carry/borrow across all digits in a single cycle. A carry
    // surviving past the top digit means the whole value wrapped.
    always_comb begin
        next_value = value_q;
        next_wrap  = 1'b0;
        carry      = 1'b0;
        if (bus.i_clr) begin
            next_value = '0;
        end else if (bus.i_inc != bus.i_dec) begin
            carry = 1'b1;
            for (int k = 0; k < N_DIGITS; k++) begin
                if (carry) begin
                    if (bus.i_inc) begin
                        if (value_q[4*k +: 4] == DIGIT_MAX) begin
                            next_value[4*k +: 4] = 4'd0;
                        end else begin
                            next_value[4*k +: 4] = value_q[4*k +: 4] + 4'd1;
                            carry                = 1'b0;
                        end
                    end else begin
                        if (value_q[4*k +: 4] == 4'd0) begin
                            next_value[4*k +: 4] = DIGIT_MAX;
                        end else begin
                            next_value[4*k +: 4] = value_q[4*k +: 4] - 4'd1;
                            carry                = 1'b0;
                        end
                    end
                end
            end
            next_wrap = carry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= next_value;
            wrap_q  <= next_wrap;
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digits
        assign digits[g] = value_q[4*g +: 4];
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        lead_blank  = '0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            higher_zero   = higher_zero & (digits[k] == 4'd0);
            lead_blank[k] = higher_zero;
        end
    end
`else
    assign lead_blank = '0;
`endif

    // The displayed digit is read from the live value register so a count
    // change reaches the tube on the very next output update.
    always_comb begin
        cur_digit   = digits[scan_index];
        cur_sel     = N_DIGITS'(1) << scan_index;
        cur_pattern = seg7_decode(cur_digit);
        if (RADIX == 10 && cur_digit > 4'd9) begin
            cur_pattern = SEG_OFF;
        end
        if (lead_blank[scan_index]) begin
            cur_pattern = SEG_OFF;
        end
    end

    // Select and segments share one register stage so they switch together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_sel         <= SEL_POL;
            bus.o_digitalTube <= SEG_OFF ^ SEG_POL;
        end else begin
            bus.o_sel         <= cur_sel ^ SEL_POL;
            bus.o_digitalTube <= cur_pattern ^ SEG_POL;
        end
    end

    assign bus.o_value = value_q;
    assign bus.o_wrap  = wrap_q;

endmodule
